// File: rtl/connect4_pkg.sv
// Shared types for the connect-4 game controller: FSM states, the BCD digit
// width and a two-digit BCD pair with a binary-to-BCD helper.
package connect4_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_e;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd2_t;

  // Valid for 0..99; used only on elaboration-time constants.
  function automatic bcd2_t to_bcd2(input int value);
    bcd2_t r;
    r.tens = BCD_W'(value / 10);
    r.ones = BCD_W'(value % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_down_counter2.sv
// Two-digit BCD register with synchronous load and a saturating decrement
// (the value never wraps below 00).
module bcd_down_counter2
  import connect4_pkg::*;
#(
  parameter bcd2_t RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load_i,
  input  bcd2_t            load_val_i,
  input  logic             dec_i,
  output logic [BCD_W-1:0] tens_o,
  output logic [BCD_W-1:0] ones_o,
  output logic             zero_o
);

  bcd2_t cnt_q, cnt_d;

  // NOTE: cnt_d takes its hold value first so every path assigns it and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && !zero_o) begin
      if (cnt_q.ones == '0) begin
        cnt_d.ones = BCD_W'(9);
        cnt_d.tens = cnt_q.tens - 1'b1;
      end else begin
        cnt_d.ones = cnt_q.ones - 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= RESET_VAL;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
  assign tens_o = cnt_q.tens;
  assign ones_o = cnt_q.ones;

endmodule

// File: rtl/turn_timer.sv
// Per-turn countdown timer: a one-second prescaler drives a two-digit BCD
// down counter; the turn ends on move_done (IDLE) or on reaching 00 (EXPIRED).
module turn_timer
  import connect4_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int TURN_SECONDS  = 30
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             pause,
  input  logic             move_done,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             running,
  output logic             expired,
  output logic             timeout
);

  localparam int            PW         = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam bcd2_t         TURN_BCD   = to_bcd2(TURN_SECONDS);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          timeout_q, timeout_d;
  logic          cnt_load, cnt_dec, cnt_zero;
  logic          last_second;

  bcd_down_counter2 #(
    .RESET_VAL (TURN_BCD)
  ) u_digits (
    .clock      (clock),
    .resetn     (resetn),
    .load_i     (cnt_load),
    .load_val_i (TURN_BCD),
    .dec_i      (cnt_dec),
    .tens_o     (tens),
    .ones_o     (ones),
    .zero_o     (cnt_zero)
  );

  assign last_second = (tens == '0) && (ones == BCD_W'(1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      timeout_q <= timeout_d;
    end
  end

  // start overrides everything; move_done beats a coincident second tick.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (start) begin
      state_d  = RUN;
      presc_d  = '0;
      cnt_load = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (move_done) begin
            state_d = IDLE;
          end else if (!pause) begin
            if (presc_q == PRESC_LAST) begin
              presc_d = '0;
              cnt_dec = !cnt_zero;
              if (last_second) state_d = EXPIRED;
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end
        end
        IDLE, EXPIRED: state_d = state_q;
        default:       state_d = IDLE;
      endcase
    end
  end

  // timeout is registered so it rises on the same edge that enters EXPIRED.
  always_comb begin
    running   = (state_q == RUN);
    expired   = (state_q == EXPIRED);
    timeout   = timeout_q;
    timeout_d = (state_d == EXPIRED) && (state_q != EXPIRED);
  end

endmodule

// File: tb/tb_turn_timer.sv
// Scoreboard bench for turn_timer: a 3-second and a 10-second instance, both
// at 4 clocks per second; expected output tuples are queued then compared.
module tb_turn_timer;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       expired;
    logic       timeout;
  } obs_t;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0, pause = 1'b0, move_done = 1'b0;
  logic [3:0] tens, ones;
  logic       running, expired, timeout;
  logic       start10 = 1'b0, pause10 = 1'b0, move10 = 1'b0;
  logic [3:0] tens10, ones10;
  logic       running10, expired10, timeout10;

  obs_t exp_q[$];
  obs_t got, want;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  turn_timer #(.TICKS_PER_SEC(4), .TURN_SECONDS(3)) dut (
    .clock(clock), .resetn(resetn), .start(start), .pause(pause),
    .move_done(move_done), .tens(tens), .ones(ones), .running(running),
    .expired(expired), .timeout(timeout)
  );

  turn_timer #(.TICKS_PER_SEC(4), .TURN_SECONDS(10)) dut10 (
    .clock(clock), .resetn(resetn), .start(start10), .pause(pause10),
    .move_done(move10), .tens(tens10), .ones(ones10), .running(running10),
    .expired(expired10), .timeout(timeout10)
  );

  function automatic obs_t mk(input int t, input int o, input bit r, input bit e, input bit to);
    obs_t v;
    v.tens    = 4'(t);
    v.ones    = 4'(o);
    v.running = r;
    v.expired = e;
    v.timeout = to;
    return v;
  endfunction

  function automatic obs_t obs3();
    return {tens, ones, running, expired, timeout};
  endfunction

  function automatic obs_t obs10();
    return {tens10, ones10, running10, expired10, timeout10};
  endfunction

  function automatic string fmt(input obs_t v);
    return $sformatf("%0d%0d run=%b exp=%b tmo=%b", v.tens, v.ones, v.running, v.expired, v.timeout);
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    exp_q.push_back(mk(0, 3, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 0));
    got = obs3(); want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL reset_hold3 got %s want %s", fmt(got), fmt(want));
    end
    got = obs10(); want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL reset_hold10 got %s want %s", fmt(got), fmt(want));
    end
    @(negedge clock);
    resetn = 1'b1;
    for (int k = 0; k < 20; k++) exp_q.push_back(mk(0, 3, 0, 0, 0));
    for (int k = 0; k < 20; k++) begin
      @(posedge clock); #1;
      got = obs3(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL reset_idle k=%0d got %s want %s", k, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_timeout();
    start = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k < 12) exp_q.push_back(mk(0, 3 - k / 4, 1, 0, 0));
      else        exp_q.push_back(mk(0, 0, 0, 1, k == 12));
    end
    for (int k = 0; k < 16; k++) begin
      @(posedge clock); #1;
      start = 1'b0;
      got = obs3(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL timeout k=%0d got %s want %s", k, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_pause();
    start = 1'b1;
    for (int k = 0; k < 17; k++) exp_q.push_back(mk(0, (k < 14) ? 3 : 2, 1, 0, 0));
    for (int k = 0; k < 17; k++) begin
      @(posedge clock); #1;
      start = 1'b0;
      got = obs3(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL pause k=%0d got %s want %s", k, fmt(got), fmt(want));
      end
      pause = (k >= 1 && k <= 10);
    end
    pause = 1'b0;
  endtask

  task automatic test_move_done();
    start = 1'b1;
    for (int k = 0; k < 26; k++) begin
      if (k < 4)      exp_q.push_back(mk(0, 3, 1, 0, 0));
      else if (k < 6) exp_q.push_back(mk(0, 2, 1, 0, 0));
      else            exp_q.push_back(mk(0, 2, 0, 0, 0));
    end
    for (int k = 0; k < 26; k++) begin
      @(posedge clock); #1;
      start = 1'b0;
      got = obs3(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL move_done k=%0d got %s want %s", k, fmt(got), fmt(want));
      end
      move_done = (k == 5 || k == 12);
    end
    move_done = 1'b0;
  endtask

  task automatic test_borrow_priority();
    start10 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if ((k >= 4 && k < 6) || k >= 10) exp_q.push_back(mk(0, 9, 1, 0, 0));
      else                              exp_q.push_back(mk(1, 0, 1, 0, 0));
    end
    for (int k = 0; k < 12; k++) begin
      @(posedge clock); #1;
      got = obs10(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL borrow_prio k=%0d got %s want %s", k, fmt(got), fmt(want));
      end
      start10 = (k == 5);
      move10  = (k == 5);
    end
    start10 = 1'b0;
    move10  = 1'b0;
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    for (int k = 0; k < 10; k++) exp_q.push_back(mk(0, 3 - k / 4, 1, 0, 0));
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      start = 1'b0;
      got = obs3(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL reset_mid_run k=%0d got %s want %s", k, fmt(got), fmt(want));
      end
    end
    #1 resetn = 1'b0;
    #1;
    exp_q.push_back(mk(0, 3, 0, 0, 0));
    got = obs3(); want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL reset_mid_async got %s want %s", fmt(got), fmt(want));
    end
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    for (int k = 0; k < 20; k++) exp_q.push_back(mk(0, 3, 0, 0, 0));
    for (int k = 0; k < 20; k++) begin
      @(posedge clock); #1;
      got = obs3(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL reset_mid_after k=%0d got %s want %s", k, fmt(got), fmt(want));
      end
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_pause();
    test_move_done();
    test_borrow_priority();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/turn_timer.md
TURN_TIMER -- requirements
Module: turn_timer

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 50000000, clock cycles per one-second decrement (minimum 2).
REQ-002 SHALL have parameter TURN_SECONDS, default 30, per-turn time budget (range 1..99).
REQ-003 SHALL have port clock, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, one-cycle pulse that begins a new turn.
REQ-006 SHALL have port pause, input, 1, level; while high, countdown is frozen.
REQ-007 SHALL have port move_done, input, 1, one-cycle pulse marking that the current player has dropped a piece.
REQ-008 SHALL have port tens, output, 4, BCD tens digit of the remaining seconds, driving a 7-segment hex decoder.
REQ-009 SHALL have port ones, output, 4, BCD ones digit of the remaining seconds, driving a second 7-segment hex decoder.
REQ-010 SHALL have port running, output, 1, high while in RUN.
REQ-011 SHALL have port expired, output, 1, high while in EXPIRED.
REQ-012 SHALL have port timeout, output, 1, registered pulse on entry to EXPIRED.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, EXPIRED.
REQ-014 SHALL, on start in any state: load tens/ones with BCD of TURN_SECONDS, clear the prescaler, and enter RUN on the next edge.
REQ-015 SHALL give start priority over move_done, pause and the second tick in the same cycle.
REQ-016 SHALL, in RUN with pause low, increment the prescaler each cycle, wrapping 0..TICKS_PER_SEC-1; the wrap cycle is the second tick.
REQ-017 SHALL, in RUN with pause high, hold both the prescaler and the digits; no tick is generated.
REQ-018 SHALL, on a second tick, decrement the 2-digit BCD value: ones 0 becomes 9 with a tens borrow; otherwise ones decrements.
REQ-019 SHALL, on a second tick that makes the value 00, enter EXPIRED on the same edge that writes 00.
REQ-020 SHALL, on move_done in RUN without start, enter IDLE and hold the displayed digits.
REQ-021 SHALL ignore move_done in IDLE and EXPIRED.
REQ-022 SHALL assert timeout for exactly one cycle: the first cycle in which the state is EXPIRED.
REQ-023 SHALL hold tens=0 and ones=0 in EXPIRED until start or reset.
REQ-024 SHALL never produce a BCD digit above 9, and SHALL never decrement below 00.
REQ-025 SHALL size the prescaler to $clog2(TICKS_PER_SEC) bits.

Reset
REQ-026 SHALL, while resetn is low, force: state IDLE, prescaler 0, tens/ones = BCD of TURN_SECONDS, running 0, expired 0, timeout 0.
REQ-027 SHALL, when resetn is asserted mid-RUN, abort the turn immediately; no timeout pulse results.
REQ-028 SHALL ignore start until the first rising clock edge after resetn deasserts.

Structure
REQ-029 SHALL take the state enum (IDLE, RUN, EXPIRED) and the BCD digit width constant from the shared package connect4_pkg.
REQ-030 SHALL place the 2-digit BCD load/decrement logic in one sub-module, bcd_down_counter2.
REQ-031 SHALL have bcd_down_counter2 take load, load value, and dec inputs, and produce tens, ones, and zero outputs.

Verification (TICKS_PER_SEC=4, TURN_SECONDS=3 unless stated)
REQ-032 SHALL cover reset: resetn low, then high with no other input -> tens=0, ones=3, running=0, expired=0 indefinitely.
REQ-033 SHALL cover timeout: start pulse -> running=1, ones goes 3->2->1->0 at 4-cycle intervals; expired=1 and timeout high for exactly 1 cycle, both on the edge writing 00.
REQ-034 SHALL cover pause: pause high for 10 cycles mid-second -> digits and remaining tick distance unchanged; after release, the decrement lands 10 cycles later than the unpaused case.
REQ-035 SHALL cover move_done: pulse at value 2 -> IDLE, running=0, digits held at 02; no timeout is ever seen.
REQ-036 SHALL cover borrow and priority with TURN_SECONDS=10: start -> 10 then 09; start and move_done in the same cycle -> reload to 10, state RUN.
REQ-037 SHALL cover reset mid-turn: resetn pulsed low at value 1 -> immediate IDLE, digits 03, timeout never asserted.
